// File: rtl/video_timing_gen_if.sv
// Video timing bus: horizontal count/terminal-count from the upstream pixel counter
// in, registered sync/DE/coordinates/strobes out to the TMDS encoder stage.
interface video_timing_gen_if;
   logic [10:0] h_count;
   logic        h_tc;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [10:0] x;
   logic [9:0]  y;
   logic        line_start;
   logic        frame_start;
   logic        timing_err;

   modport master (
      input  h_count, h_tc,
      output hsync, vsync, de, x, y, line_start, frame_start, timing_err
   );

   modport slave (
      output h_count, h_tc,
      input  hsync, vsync, de, x, y, line_start, frame_start, timing_err
   );
endinterface

// File: rtl/video_timing_gen.sv
// Video timing generator: vertical line counter and phase FSM driven by the upstream
// horizontal counter. Define VIDEO_TIMING_CHECK_EN to add the sticky h_count sequence checker.
module video_timing_gen #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 48,
   parameter int H_SYNC   = 104,
   parameter int H_BP     = 75,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic               clock,
   input  logic               MR_n,
   video_timing_gen_if.master vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
   localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] H_END     = 11'(H_TOTAL);
   localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0]  VFP_START = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VBP_START = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {ST_V_ACT, ST_V_FP, ST_V_SYNC, ST_V_BP} vstate_t;

   vstate_t     state;
   vstate_t     state_next;
   logic [9:0]  v_count;
   logic [9:0]  v_next;
   logic        h_tc_d;
   logic        advance;
   logic        h_act;
   logic        hs_on;
   logic        de_next;

   // The advanced line number feeds this cycle's outputs so h_count 0 and the new line agree.
   always_comb begin
      advance    = vid.h_tc & ~h_tc_d;
      v_next     = v_count;
      state_next = state;
      if (advance) begin
         v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
         unique case (state)
            ST_V_ACT:  if (v_next == VFP_START) state_next = ST_V_FP;
            ST_V_FP:   if (v_next == VS_START)  state_next = ST_V_SYNC;
            ST_V_SYNC: if (v_next == VBP_START) state_next = ST_V_BP;
            ST_V_BP:   if (v_next == '0)        state_next = ST_V_ACT;
            default:   state_next = ST_V_ACT;
         endcase
      end
      h_act   = (vid.h_count < H_ACT_END) && (vid.h_count < H_END);
      hs_on   = (vid.h_count >= HS_START) && (vid.h_count < HS_END) && (vid.h_count < H_END);
      de_next = h_act && (state_next == ST_V_ACT);
   end

   always_ff @(posedge clock or negedge MR_n) begin
      if (!MR_n) begin
         h_tc_d          <= 1'b0;
         v_count         <= '0;
         state           <= ST_V_ACT;
         vid.hsync       <= ~HS_POL;
         vid.vsync       <= ~VS_POL;
         vid.de          <= 1'b0;
         vid.x           <= '0;
         vid.y           <= '0;
         vid.line_start  <= 1'b0;
         vid.frame_start <= 1'b0;
      end else begin
         h_tc_d          <= vid.h_tc;
         v_count         <= v_next;
         state           <= state_next;
         vid.hsync       <= hs_on ? HS_POL : ~HS_POL;
         vid.vsync       <= (state_next == ST_V_SYNC) ? VS_POL : ~VS_POL;
         vid.de          <= de_next;
         vid.x           <= de_next ? vid.h_count : '0;
         vid.y           <= de_next ? v_next : '0;
         vid.line_start  <= advance;
         vid.frame_start <= advance & (v_next == '0);
      end
   end

`ifdef VIDEO_TIMING_CHECK_EN
   logic [10:0] h_prev;

   // A count that neither holds, steps by one, nor restarts at 0 means a skip or bad load.
   always_ff @(posedge clock or negedge MR_n) begin
      if (!MR_n) begin
         h_prev         <= '0;
         vid.timing_err <= 1'b0;
      end else begin
         h_prev <= vid.h_count;
         if ((vid.h_count != h_prev) && (vid.h_count != h_prev + 11'd1) && (vid.h_count != '0))
            vid.timing_err <= 1'b1;
      end
   end
`else
   assign vid.timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized self-checking bench for video_timing_gen against a line-number/range model
// of the 1024x768 timing; follows VIDEO_TIMING_CHECK_EN the same way the design does.
module tb_video_timing_gen;

   localparam int V_TOTAL = 806;

   logic clock = 1'b0;
   logic MR_n  = 1'b0;

   video_timing_gen_if vif ();

   video_timing_gen dut (
      .clock (clock),
      .MR_n  (MR_n),
      .vid   (vif)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Reference model: absolute line number, previous count and the sticky error.
   int          m_v;
   bit          m_tc_d;
   int          m_prev;
   bit          m_err;
   logic [26:0] exp_vec;
   bit          exp_de;
   bit          exp_ls;

   function automatic logic [26:0] observed();
      return {vif.hsync, vif.vsync, vif.de, vif.x, vif.y,
              vif.line_start, vif.frame_start, vif.timing_err};
   endfunction

   task automatic model_reset();
      m_v     = 0;
      m_tc_d  = 1'b0;
      m_prev  = 0;
      m_err   = 1'b0;
      exp_vec = '0;
   endtask

   // Drive one pixel at the falling edge, predict the registered outputs, sample 1 ns after the rise.
   task automatic drive(input int cnt, input bit tc);
      bit adv, hs, vs, fs;
      @(negedge clock);
      vif.h_count = 11'(cnt);
      vif.h_tc    = tc;
      adv    = tc && !m_tc_d;
      m_tc_d = tc;
      if (adv) m_v = (m_v + 1) % V_TOTAL;
      exp_de = (cnt < 1024) && (m_v < 768);
      hs     = (cnt >= 1072) && (cnt < 1176);
      vs     = (m_v >= 771) && (m_v <= 776);
      fs     = adv && (m_v == 0);
      exp_ls = adv;
`ifdef VIDEO_TIMING_CHECK_EN
      if ((cnt != m_prev) && (cnt != ((m_prev + 1) % 2048)) && (cnt != 0)) m_err = 1'b1;
`endif
      m_prev  = cnt;
      exp_vec = {hs, vs, exp_de, exp_de ? 11'(cnt) : 11'd0, exp_de ? 10'(m_v) : 10'd0,
                 adv, fs, m_err};
      @(posedge clock);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clock);
      vif.h_count = '0;
      vif.h_tc    = 1'b0;
      MR_n        = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      MR_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         vif.h_count = 11'($urandom_range(0, 2047));
         vif.h_tc    = 1'($urandom_range(0, 1));
         @(posedge clock);
         #1;
         checks++;
         if (observed() !== 27'd0) begin
            errors++;
            $display("[TB] FAIL reset cycle %0d: got %h expected %h", i, observed(), 27'd0);
         end
      end
      release_reset();
   endtask

   task automatic test_line0();
      int ls_seen, hs_cycles, de_cycles;
      ls_seen = 0; hs_cycles = 0; de_cycles = 0;
      for (int line = 0; line < 2; line++) begin
         for (int c = 0; c < 1251; c++) begin
            drive(c, (line == 1) && (c == 0));
            checks++;
            if (observed() !== exp_vec) begin
               errors++;
               $display("[TB] FAIL line%0d pixel %0d: got %h expected %h", line, c, observed(), exp_vec);
            end
            if (line == 1) begin
               ls_seen   += int'(vif.line_start);
               hs_cycles += int'(vif.hsync);
               de_cycles += int'(vif.de);
            end
         end
      end
      checks++;
      if (ls_seen !== 1) begin
         errors++;
         $display("[TB] FAIL line_start_count: got %0d expected 1", ls_seen);
      end
      checks++;
      if (hs_cycles !== 104) begin
         errors++;
         $display("[TB] FAIL hsync_width: got %0d expected 104", hs_cycles);
      end
      checks++;
      if (de_cycles !== 1024) begin
         errors++;
         $display("[TB] FAIL de_width: got %0d expected 1024", de_cycles);
      end
   endtask

   task automatic test_frame_wrap();
      int fs_seen, vs_lines, de_lines, stall, len;
      fs_seen = 0; vs_lines = 0; de_lines = 0;
      for (int n = 0; n < V_TOTAL; n++) begin
         stall = $urandom_range(1, 3);
         len   = $urandom_range(1, 6);
         for (int s = 0; s < stall; s++) begin
            drive(0, 1'b1);
            checks++;
            if (observed() !== exp_vec) begin
               errors++;
               $display("[TB] FAIL frame line %0d start: got %h expected %h", n, observed(), exp_vec);
            end
            if (s == 0) begin
               fs_seen  += int'(vif.frame_start);
               vs_lines += int'(vif.vsync);
               de_lines += int'(vif.de);
            end
         end
         for (int c = 1; c <= len; c++) begin
            drive(c, 1'b0);
            checks++;
            if (observed() !== exp_vec) begin
               errors++;
               $display("[TB] FAIL frame line %0d pixel %0d: got %h expected %h", n, c, observed(), exp_vec);
            end
         end
      end
      checks++;
      if (fs_seen !== 1) begin
         errors++;
         $display("[TB] FAIL frame_start_count: got %0d expected 1", fs_seen);
      end
      checks++;
      if (vs_lines !== 6) begin
         errors++;
         $display("[TB] FAIL vsync_lines: got %0d expected 6", vs_lines);
      end
      checks++;
      if (de_lines !== 768) begin
         errors++;
         $display("[TB] FAIL de_lines: got %0d expected 768", de_lines);
      end
   endtask

   task automatic test_stall();
      int v_before, ls_seen;
      logic [9:0] y_first;
      ls_seen  = 0;
      v_before = m_v;
      for (int s = 0; s < 5; s++) begin
         drive(0, 1'b1);
         if (s == 0) y_first = vif.y;
         ls_seen += int'(vif.line_start);
         checks++;
         if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL stall cycle %0d: got %h expected %h", s, observed(), exp_vec);
         end
      end
      for (int c = 1; c < 4; c++) drive(c, 1'b0);
      checks++;
      if (ls_seen !== 1) begin
         errors++;
         $display("[TB] FAIL stall_line_start: got %0d expected 1", ls_seen);
      end
      checks++;
      if (y_first !== 10'((v_before + 1) % V_TOTAL)) begin
         errors++;
         $display("[TB] FAIL stall_y: got %0d expected %0d", y_first, (v_before + 1) % V_TOTAL);
      end
   endtask

   task automatic test_reset_mid();
      logic [9:0] y_seen;
      while (m_v != 400) begin
         drive(0, 1'b1);
         drive(1, 1'b0);
      end
      for (int c = 2; c <= 500; c++) drive(c, 1'b0);
      checks++;
      if (observed() !== exp_vec) begin
         errors++;
         $display("[TB] FAIL mid_frame pixel 500: got %h expected %h", observed(), exp_vec);
      end
      #2;
      MR_n = 1'b0;
      #1;
      checks++;
      if (observed() !== 27'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: got %h expected %h", observed(), 27'd0);
      end
      repeat (2) @(posedge clock);
      release_reset();
      for (int c = 0; c <= 20; c++) drive(c, 1'b0);
      drive(0, 1'b1);
      y_seen = vif.y;
      checks++;
      if (observed() !== exp_vec) begin
         errors++;
         $display("[TB] FAIL restart wrap: got %h expected %h", observed(), exp_vec);
      end
      checks++;
      if (y_seen !== 10'd1) begin
         errors++;
         $display("[TB] FAIL restart_y: got %0d expected 1", y_seen);
      end
      for (int c = 1; c <= 5; c++) begin
         drive(c, 1'b0);
         checks++;
         if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL restart pixel %0d: got %h expected %h", c, observed(), exp_vec);
         end
      end
   endtask

   task automatic test_out_of_range();
      int cnt;
      for (int i = 0; i < 20; i++) begin
         cnt = $urandom_range(1251, 2047);
         drive(cnt, 1'b0);
         checks++;
         if ((observed() !== exp_vec) || (vif.de !== 1'b0) || (vif.hsync !== 1'b0)) begin
            errors++;
            $display("[TB] FAIL out_of_range count %0d: got %h expected %h", cnt, observed(), exp_vec);
         end
      end
      drive(0, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         drive(c, 1'b0);
         checks++;
         if ((observed() !== exp_vec) || (vif.de !== exp_de)) begin
            errors++;
            $display("[TB] FAIL recovery pixel %0d: got %h expected %h", c, observed(), exp_vec);
         end
      end
   endtask

   task automatic test_timing_check();
      logic exp_err;
`ifdef VIDEO_TIMING_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      @(negedge clock);
      MR_n = 1'b0;
      repeat (2) @(posedge clock);
      release_reset();
      for (int c = 0; c <= 10; c++) drive(c, 1'b0);
      checks++;
      if (vif.timing_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_before_skip: got %b expected 0", vif.timing_err);
      end
      for (int c = 12; c <= 20; c++) begin
         drive(c, 1'b0);
         checks++;
         if ((vif.timing_err !== exp_err) || (observed() !== exp_vec)) begin
            errors++;
            $display("[TB] FAIL err_after_skip count %0d: got %b expected %b", c, vif.timing_err, exp_err);
         end
      end
      @(negedge clock);
      MR_n = 1'b0;
      #1;
      checks++;
      if (vif.timing_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_cleared: got %b expected 0", vif.timing_err);
      end
      release_reset();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vif.h_count = '0;
      vif.h_tc    = 1'b0;
      model_reset();
      test_reset();
      test_line0();
      test_frame_wrap();
      test_stall();
      test_reset_mid();
      test_out_of_range();
      test_timing_check();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
